// File: rtl/experiar_memory_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | experiar_memory_pkg                                                   |
// | Shared state encoding and arbitration-mode constants for the SRAM     |
// | arbiter slice.                                                        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package experiar_memory_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } memState_t;

    localparam int c_ARB_ROUND_ROBIN    = 0;
    localparam int c_ARB_FIXED_PRIORITY = 1;

endpackage
`default_nettype wire

// File: rtl/round_robin_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | round_robin_arbiter                                                   |
// | One-hot grant selection, round-robin or fixed priority (index 0 top). |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module round_robin_arbiter
    import experiar_memory_pkg::*;
#(
    parameter int PORT_COUNT       = 2,
    parameter int ARBITRATION_MODE = c_ARB_ROUND_ROBIN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PORT_COUNT-1:0] i_request,
    output logic [PORT_COUNT-1:0] o_grant
);

    localparam int c_IDX_W = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;

    logic [c_IDX_W-1:0] r_pointer;
    logic [c_IDX_W-1:0] w_grantIdx;
    logic               w_found;
    int                 w_candidate;

    // Search starts just after the last-granted index so every requester is reached within PORT_COUNT grants.
    always_comb begin
        o_grant     = '0;
        w_grantIdx  = r_pointer;
        w_found     = 1'b0;
        w_candidate = 0;
        for (int k = 0; k < PORT_COUNT; k++) begin
            if (ARBITRATION_MODE == c_ARB_FIXED_PRIORITY) begin
                w_candidate = k;
            end else begin
                w_candidate = (int'(r_pointer) + 1 + k) % PORT_COUNT;
            end
            if (!w_found && i_request[w_candidate]) begin
                w_found              = 1'b1;
                o_grant[w_candidate] = 1'b1;
                w_grantIdx           = c_IDX_W'(w_candidate);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pointer <= c_IDX_W'(PORT_COUNT - 1);
        end else if (w_found) begin
            r_pointer <= w_grantIdx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/multi_port_sram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multi_port_sram_arbiter                                               |
// | Shares one banked single-port SRAM among PORT_COUNT requesters.       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module multi_port_sram_arbiter
    import experiar_memory_pkg::*;
#(
    parameter int PORT_COUNT        = 2,
    parameter int SRAM_ADDRESS_SIZE = 9,
    parameter int BANK_SELECT_BITS  = 1,
    parameter int ARBITRATION_MODE  = c_ARB_ROUND_ROBIN
) (
    input  logic                                  wb_clk_i,
    input  logic                                  wb_rst_i,
    input  logic [PORT_COUNT-1:0]                 port_enable,
    input  logic [PORT_COUNT-1:0]                 port_writeEnable,
    input  logic [4*PORT_COUNT-1:0]               port_byteSelect,
    input  logic [24*PORT_COUNT-1:0]              port_address,
    input  logic [32*PORT_COUNT-1:0]              port_dataWrite,
    output logic [32*PORT_COUNT-1:0]              port_dataRead,
    output logic [PORT_COUNT-1:0]                 port_busy,
    output logic [PORT_COUNT-1:0]                 port_fault,
    output logic                                  clk0,
    output logic [(2**BANK_SELECT_BITS)-1:0]      csb0,
    output logic                                  web0,
    output logic [3:0]                            wmask0,
    output logic [SRAM_ADDRESS_SIZE-1:0]          addr0,
    output logic [31:0]                           din0,
    input  logic [32*(2**BANK_SELECT_BITS)-1:0]   dout0
);

    localparam int c_BANK_COUNT = 2**BANK_SELECT_BITS;
    localparam int c_BANK_W     = (BANK_SELECT_BITS > 0) ? BANK_SELECT_BITS : 1;
    localparam int c_USED_BITS  = SRAM_ADDRESS_SIZE + 2 + BANK_SELECT_BITS;

    memState_t             r_state;
    memState_t             w_nextState;
    logic [PORT_COUNT-1:0] w_request;
    logic [PORT_COUNT-1:0] w_grant;
    logic [PORT_COUNT-1:0] w_complete;
    logic [PORT_COUNT-1:0] r_readPort;
    logic [c_BANK_W-1:0]   w_selBank;
    logic [c_BANK_W-1:0]   r_readBank;
    logic [23:0]           w_selAddress;
    logic [31:0]           w_selData;
    logic [3:0]            w_selByte;
    logic                  w_selWrite;
    logic                  w_outOfRange;
    logic [31:0]           w_bankData;
    logic                  w_unusedAddrBits;

    assign clk0             = wb_clk_i;
    assign w_unusedAddrBits = ^w_selAddress[1:0];
    // No new grants while a read is outstanding or in reset.
    assign w_request        = (r_state == ST_IDLE && !wb_rst_i) ? port_enable : '0;
    assign port_busy        = port_enable & ~w_complete;

    round_robin_arbiter #(
        .PORT_COUNT       (PORT_COUNT),
        .ARBITRATION_MODE (ARBITRATION_MODE)
    ) u_arbiter (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .i_request (w_request),
        .o_grant   (w_grant)
    );

    always_comb begin
        w_selAddress = '0;
        w_selData    = '0;
        w_selByte    = '0;
        w_selWrite   = 1'b0;
        for (int i = 0; i < PORT_COUNT; i++) begin
            if (w_grant[i]) begin
                w_selAddress = port_address[i*24 +: 24];
                w_selData    = port_dataWrite[i*32 +: 32];
                w_selByte    = port_byteSelect[i*4 +: 4];
                w_selWrite   = port_writeEnable[i];
            end
        end
    end

    if (BANK_SELECT_BITS > 0) begin : g_bankField
        assign w_selBank = w_selAddress[SRAM_ADDRESS_SIZE+2 +: c_BANK_W];
    end else begin : g_singleBank
        assign w_selBank = 1'b0;
    end

    if (c_USED_BITS < 24) begin : g_rangeCheck
        assign w_outOfRange = |w_selAddress[23:c_USED_BITS];
    end else begin : g_fullRange
        assign w_outOfRange = 1'b0;
    end

    always_comb begin
        w_bankData = '0;
        for (int b = 0; b < c_BANK_COUNT; b++) begin
            if (c_BANK_W'(b) == r_readBank) begin
                w_bankData = dout0[b*32 +: 32];
            end
        end
    end

    always_comb begin
        w_nextState   = r_state;
        w_complete    = '0;
        port_fault    = '0;
        port_dataRead = '0;
        csb0          = '1;
        web0          = 1'b1;
        wmask0        = '0;
        addr0         = '0;
        din0          = '0;
        case (r_state)
            ST_IDLE: begin
                if (|w_grant) begin
                    if (w_outOfRange) begin
                        w_complete = w_grant;
                        port_fault = w_grant;
                        for (int i = 0; i < PORT_COUNT; i++) begin
                            if (w_grant[i]) begin
                                port_dataRead[i*32 +: 32] = 32'hFFFF_FFFF;
                            end
                        end
                    end else begin
                        for (int b = 0; b < c_BANK_COUNT; b++) begin
                            if (c_BANK_W'(b) == w_selBank) begin
                                csb0[b] = 1'b0;
                            end
                        end
                        web0   = ~w_selWrite;
                        wmask0 = w_selByte;
                        addr0  = w_selAddress[SRAM_ADDRESS_SIZE+1:2];
                        din0   = w_selData;
                        if (w_selWrite) begin
                            w_complete = w_grant;
                        end else begin
                            w_nextState = ST_READ;
                        end
                    end
                end
            end
            ST_READ: begin
                // Completes even if the requester dropped enable meanwhile.
                w_complete  = r_readPort;
                w_nextState = ST_IDLE;
                for (int i = 0; i < PORT_COUNT; i++) begin
                    if (r_readPort[i]) begin
                        port_dataRead[i*32 +: 32] = w_bankData;
                    end
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
        if (wb_rst_i) begin
            w_complete    = '0;
            port_fault    = '0;
            port_dataRead = '0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state    <= ST_IDLE;
            r_readPort <= '0;
            r_readBank <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == ST_IDLE && w_nextState == ST_READ) begin
                r_readPort <= w_grant;
                r_readBank <= w_selBank;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_port_sram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_multi_port_sram_arbiter                                            |
// | Self-checking bench: vector table, corner sequences, random traffic.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_multi_port_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  en, we, busy, fault;
    logic [7:0]  bs;
    logic [47:0] addr;
    logic [63:0] wd, rd, dout;
    logic        clk0, web;
    logic [1:0]  csb;
    logic [3:0]  wmask;
    logic [8:0]  a0;
    logic [31:0] din;

    logic        fRst;
    logic [1:0]  fEn, fWe, fBusy, fFault, fCsb;
    logic [7:0]  fBs;
    logic [47:0] fAddr;
    logic [63:0] fWd, fRd, fDout;
    logic        fClk0, fWeb;
    logic [3:0]  fWmask;
    logic [8:0]  fA0;
    logic [31:0] fDin;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multi_port_sram_arbiter #(
        .PORT_COUNT(2), .SRAM_ADDRESS_SIZE(9), .BANK_SELECT_BITS(1), .ARBITRATION_MODE(0)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .port_enable(en), .port_writeEnable(we),
        .port_byteSelect(bs), .port_address(addr), .port_dataWrite(wd),
        .port_dataRead(rd), .port_busy(busy), .port_fault(fault), .clk0(clk0),
        .csb0(csb), .web0(web), .wmask0(wmask), .addr0(a0), .din0(din), .dout0(dout)
    );

    multi_port_sram_arbiter #(
        .PORT_COUNT(2), .SRAM_ADDRESS_SIZE(9), .BANK_SELECT_BITS(1), .ARBITRATION_MODE(1)
    ) dutFixed (
        .wb_clk_i(clk), .wb_rst_i(fRst), .port_enable(fEn), .port_writeEnable(fWe),
        .port_byteSelect(fBs), .port_address(fAddr), .port_dataWrite(fWd),
        .port_dataRead(fRd), .port_busy(fBusy), .port_fault(fFault), .clk0(fClk0),
        .csb0(fCsb), .web0(fWeb), .wmask0(fWmask), .addr0(fA0), .din0(fDin), .dout0(fDout)
    );

    // Two-bank SRAM behavioural model: registered read data, byte-masked writes.
    logic [31:0] sram [2][512];
    logic [31:0] sramOut [2];
    assign dout = {sramOut[1], sramOut[0]};

    always @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (!csb[b]) begin
                if (!web) begin
                    for (int j = 0; j < 4; j++) begin
                        if (wmask[j]) sram[b][a0][j*8 +: 8] <= din[j*8 +: 8];
                    end
                end else begin
                    sramOut[b] <= sram[b][a0];
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setPort(input int p, input logic e, input logic w, input logic [3:0] b,
                           input logic [23:0] ad, input logic [31:0] d);
        en[p]          = e;
        we[p]          = w;
        bs[p*4 +: 4]   = b;
        addr[p*24 +: 24] = ad;
        wd[p*32 +: 32] = d;
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  bs;
        logic [23:0] ad;
        logic [31:0] wdata;
        logic [1:0]  eCsb;
        logic [8:0]  eAddr;
        logic        eFault;
        logic [31:0] eData;
    } vec_t;

    vec_t tbl [8];

    // Reference model state for the random phase.
    logic [31:0] gm [2][512];
    logic [1:0]  rEn;
    logic        rWe [2];
    logic [3:0]  rBs [2];
    logic [23:0] rAd [2];
    logic [31:0] rWd [2];

    initial begin
        int          mPtr;
        bit          mRead;
        int          mPort;
        logic [31:0] mExp;
        logic [1:0]  eBusy, eFault, eCsb, done;
        logic [63:0] eRd;
        logic        eWeb, chkA;
        logic [8:0]  eA0;
        int          g, wrd, bk;
        bit          oor, isRd;

        for (int b = 0; b < 2; b++) begin
            sramOut[b] = '0;
            for (int w = 0; w < 512; w++) begin
                sram[b][w] = '0;
                gm[b][w]   = '0;
            end
        end
        tbl[0] = '{1'b1, 4'hF, 24'h000404, 32'hDEADBEEF, 2'b10, 9'h101, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 4'hF, 24'h000404, 32'h0,        2'b10, 9'h101, 1'b0, 32'hDEADBEEF};
        tbl[2] = '{1'b1, 4'h3, 24'h000800, 32'h12345678, 2'b01, 9'h000, 1'b0, 32'h0};
        tbl[3] = '{1'b0, 4'hF, 24'h000800, 32'h0,        2'b01, 9'h000, 1'b0, 32'h00005678};
        tbl[4] = '{1'b0, 4'hF, 24'h001000, 32'h0,        2'b11, 9'h000, 1'b1, 32'hFFFFFFFF};
        tbl[5] = '{1'b1, 4'hF, 24'h800000, 32'h0,        2'b11, 9'h000, 1'b1, 32'hFFFFFFFF};
        tbl[6] = '{1'b1, 4'h4, 24'h000406, 32'h00AA0000, 2'b10, 9'h101, 1'b0, 32'h0};
        tbl[7] = '{1'b0, 4'hF, 24'h000405, 32'h0,        2'b10, 9'h101, 1'b0, 32'hDEAABEEF};

        rst = 1'b1; fRst = 1'b1;
        en = '0; we = '0; bs = '0; addr = '0; wd = '0;
        fEn = '0; fWe = '0; fBs = '0; fAddr = '0; fWd = '0; fDout = '0;
        tick();
        tick();
        setPort(0, 1'b1, 1'b0, 4'hF, 24'h000040, 32'h0);
        setPort(1, 1'b1, 1'b1, 4'hF, 24'h000044, 32'h0);
        #2;
        chk("rst_busy", 64'(busy), 64'(2'b11));
        chk("rst_csb", 64'(csb), 64'(2'b11));
        chk("rst_web", 64'(web), 64'(1'b1));
        chk("rst_fault", 64'(fault), 64'(2'b00));
        tick();
        rst = 1'b0; fRst = 1'b0;
        en = '0;

        // Single-port vector table.
        for (int i = 0; i < 8; i++) begin
            isRd = !tbl[i].we && !tbl[i].eFault;
            setPort(0, 1'b1, tbl[i].we, tbl[i].bs, tbl[i].ad, tbl[i].wdata);
            #2;
            chk($sformatf("v%0d_csb", i), 64'(csb), 64'(tbl[i].eCsb));
            chk($sformatf("v%0d_fault", i), 64'(fault[0]), 64'(tbl[i].eFault));
            chk($sformatf("v%0d_busy", i), 64'(busy[0]), 64'(isRd));
            if (tbl[i].eFault) begin
                chk($sformatf("v%0d_oordata", i), 64'(rd[31:0]), 64'(tbl[i].eData));
            end else begin
                chk($sformatf("v%0d_addr", i), 64'(a0), 64'(tbl[i].eAddr));
                chk($sformatf("v%0d_web", i), 64'(web), 64'(!tbl[i].we));
                if (tbl[i].we) chk($sformatf("v%0d_din", i), 64'(din), 64'(tbl[i].wdata));
            end
            tick();
            if (isRd) begin
                #2;
                chk($sformatf("v%0d_rdata", i), 64'(rd[31:0]), 64'(tbl[i].eData));
                chk($sformatf("v%0d_rdbusy", i), 64'(busy[0]), 64'(1'b0));
                chk($sformatf("v%0d_rdcsb", i), 64'(csb), 64'(2'b11));
                tick();
            end
        end
        en = '0;

        // Preload two words, then abort a read with reset.
        setPort(0, 1'b1, 1'b1, 4'hF, 24'h000040, 32'hA0A0A0A0);
        tick();
        setPort(0, 1'b1, 1'b1, 4'hF, 24'h000044, 32'hB1B1B1B1);
        tick();
        setPort(0, 1'b1, 1'b0, 4'hF, 24'h000040, 32'h0);
        tick();
        rst = 1'b1;
        #2;
        chk("rstRead_busy", 64'(busy), 64'(2'b01));
        chk("rstRead_data", rd, 64'h0);
        chk("rstRead_csb", 64'(csb), 64'(2'b11));
        tick();
        rst = 1'b0;
        setPort(1, 1'b1, 1'b0, 4'hF, 24'h000044, 32'h0);
        #2;
        chk("first_grant_addr", 64'(a0), 64'(9'h010));
        chk("first_grant_busy", 64'(busy), 64'(2'b11));

        // Continuous reads from both ports must alternate grants.
        for (int k = 1; k <= 6; k++) begin
            tick();
            #2;
            if (k % 2 == 1) begin
                g = ((k - 1) / 2) % 2;
                chk($sformatf("alt%0d_busy", k), 64'(busy), 64'(2'b11 & ~(2'b01 << g)));
                chk($sformatf("alt%0d_data", k), 64'(rd[g*32 +: 32]),
                    64'((g == 0) ? 32'hA0A0A0A0 : 32'hB1B1B1B1));
                chk($sformatf("alt%0d_csb", k), 64'(csb), 64'(2'b11));
            end else begin
                g = (k / 2) % 2;
                chk($sformatf("alt%0d_addr", k), 64'(a0), 64'(9'h010 + 9'(g)));
                chk($sformatf("alt%0d_busy", k), 64'(busy), 64'(2'b11));
            end
        end
        tick();
        en = '0;
        #2;
        chk("dropEn_busy", 64'(busy), 64'(2'b00));
        chk("dropEn_data", 64'(rd[63:32]), 64'(32'hB1B1B1B1));
        tick();

        // Fixed priority: port 1 starves while port 0 keeps requesting.
        fEn = 2'b11; fWe = 2'b11; fBs = 8'hFF;
        fAddr = {24'h0000C4, 24'h0000C0};
        for (int k = 0; k < 5; k++) begin
            #2;
            chk($sformatf("fix%0d_busy", k), 64'(fBusy), 64'(2'b10));
            chk($sformatf("fix%0d_addr", k), 64'(fA0), 64'(9'h030));
            tick();
        end
        fEn[0] = 1'b0;
        #2;
        chk("fix_release_busy", 64'(fBusy), 64'(2'b00));
        chk("fix_release_addr", 64'(fA0), 64'(9'h031));
        tick();
        fEn = '0;

        // Random two-port traffic against a transaction-level model.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mPtr = 1; mRead = 0; mPort = 0; mExp = '0; rEn = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!rEn[p] && $urandom_range(0, 1) == 1) begin
                    rEn[p] = 1'b1;
                    rWe[p] = 1'($urandom_range(0, 1));
                    rBs[p] = 4'($urandom_range(0, 15));
                    rWd[p] = $urandom;
                    if ($urandom_range(0, 9) == 0) begin
                        rAd[p] = 24'($urandom_range(1, 4095) << 12) | 24'($urandom_range(0, 4095));
                    end else begin
                        rAd[p] = 24'(($urandom_range(0, 1) << 11) | ((32 + $urandom_range(0, 7)) << 2)
                                 | $urandom_range(0, 3));
                    end
                end
                setPort(p, rEn[p], rWe[p], rBs[p], rAd[p], rWd[p]);
            end
            #2;
            eBusy = rEn; eFault = '0; eRd = '0; eCsb = 2'b11; eWeb = 1'b1;
            chkA = 1'b0; eA0 = '0; done = '0;
            if (mRead) begin
                eBusy[mPort] = 1'b0;
                eRd[mPort*32 +: 32] = mExp;
                done[mPort] = 1'b1;
                mRead = 0;
            end else begin
                g = -1;
                for (int k = 0; k < 2; k++) begin
                    if (g < 0 && rEn[(mPtr + 1 + k) % 2]) g = (mPtr + 1 + k) % 2;
                end
                if (g >= 0) begin
                    mPtr = g;
                    wrd  = int'(rAd[g][10:2]);
                    bk   = int'(rAd[g][11]);
                    oor  = |rAd[g][23:12];
                    if (oor) begin
                        eBusy[g] = 1'b0;
                        eFault[g] = 1'b1;
                        eRd[g*32 +: 32] = 32'hFFFFFFFF;
                        done[g] = 1'b1;
                    end else begin
                        eCsb[bk] = 1'b0;
                        chkA = 1'b1;
                        eA0 = 9'(wrd);
                        if (rWe[g]) begin
                            eWeb = 1'b0;
                            eBusy[g] = 1'b0;
                            done[g] = 1'b1;
                            for (int j = 0; j < 4; j++) begin
                                if (rBs[g][j]) gm[bk][wrd][j*8 +: 8] = rWd[g][j*8 +: 8];
                            end
                        end else begin
                            mRead = 1;
                            mPort = g;
                            mExp  = gm[bk][wrd];
                        end
                    end
                end
            end
            chk($sformatf("rnd%0d_busy", cyc), 64'(busy), 64'(eBusy));
            chk($sformatf("rnd%0d_fault", cyc), 64'(fault), 64'(eFault));
            chk($sformatf("rnd%0d_data", cyc), rd, eRd);
            chk($sformatf("rnd%0d_csb", cyc), 64'(csb), 64'(eCsb));
            chk($sformatf("rnd%0d_web", cyc), 64'(web), 64'(eWeb));
            if (chkA) chk($sformatf("rnd%0d_addr", cyc), 64'(a0), 64'(eA0));
            rEn = rEn & ~done;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
